ref_sc_fifo_rd_stream: RTL and testbench

- Read-side drain engine for the team's single-clock latency-1 shallow-RAM FIFO.
- Drives the FIFO's rd_ack, samples rd_data, and presents words on a registered valid/ready stream through a 2-entry skid buffer.
- Hides the FIFO read latency and look-ahead mode from downstream logic (DMA packet builders, register read-back paths).
- Counts words delivered, for status registers.

---
 rtl/ref_sc_fifo_rd_stream_pkg.sv | 20 ++
 rtl/ref_sc_fifo_rd_stream_if.sv | 27 ++
 rtl/ref_sc_fifo_rd_stream.sv | 95 +++++++++
 tb/tb_ref_sc_fifo_rd_stream.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ref_sc_fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
// The engine and its interface both import this package.
package ref_sc_fifo_rd_stream_pkg;

    typedef enum logic {
        FETCH_OK = 1'b0,
        GAP      = 1'b1
    } gap_state_e;

    localparam int         SKID_DEPTH = 2;
    localparam logic [1:0] SKID_FULL  = 2'(SKID_DEPTH);

    // Occupancy after one cycle with an optional push and an optional pop.
    function automatic logic [1:0] skid_level_next(input logic [1:0] lvl,
                                                   input logic       push,
                                                   input logic       pop);
        return lvl + {1'b0, push} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/ref_sc_fifo_rd_stream_if.sv
// Bundle of FIFO read-port and downstream stream signals.
// The engine connects through the master modport; the FIFO/sink side uses the slave modport.
interface ref_sc_fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 32
);
    logic                  fifo_rd_empty;
    logic [ADDR_WIDTH:0]   fifo_rd_level;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_ack;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [1:0]            buf_level;
    logic [CNT_WIDTH-1:0]  word_count;

    modport master (
        input  fifo_rd_empty, fifo_rd_level, fifo_rd_data, out_ready,
        output fifo_rd_ack, out_valid, out_data, buf_level, word_count
    );

    modport slave (
        output fifo_rd_empty, fifo_rd_level, fifo_rd_data, out_ready,
        input  fifo_rd_ack, out_valid, out_data, buf_level, word_count
    );
endinterface

// File: rtl/ref_sc_fifo_rd_stream.sv
// Drains a latency-1 shallow-RAM FIFO into a registered valid/ready stream
// through a 2-entry skid buffer, and counts words accepted downstream.
module ref_sc_fifo_rd_stream
    import ref_sc_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH    = 72,
    parameter int ADDR_WIDTH    = 4,
    parameter int EN_LOOK_AHEAD = 0,
    parameter int CNT_WIDTH     = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    ref_sc_fifo_rd_stream_if.master bus
);

    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;
    logic [1:0]            lvl_q, lvl_d;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    gap_state_e            gap_q;
    logic                  ack;
    logic                  pop;
    logic [ADDR_WIDTH:0]   unused_level;

    // FIFO occupancy is reported for status only; control never looks at it.
    assign unused_level = bus.fifo_rd_level;

    // The fetch decision depends only on registered state, so out_ready never
    // reaches fifo_rd_ack and a full buffer never fetches, even while popping.
    assign ack = !bus.fifo_rd_empty && (gap_q == FETCH_OK) && (lvl_q < SKID_FULL) && !flush;
    assign pop = valid_q && bus.out_ready;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        if (flush) begin
            lvl_d = 2'd0;
        end else begin
            if (pop) begin
                e0_d  = e1_q;
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            // Land the fetched word in the first slot still free after this cycle's pop.
            if (ack) begin
                if (lvl_q == 2'd0 || pop) begin
                    e0_d = bus.fifo_rd_data;
                end else begin
                    e1_d = bus.fifo_rd_data;
                end
            end
            lvl_d = skid_level_next(lvl_q, ack, pop);
        end
        valid_d = (lvl_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            lvl_q   <= 2'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            lvl_q   <= lvl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Without look-ahead the FIFO needs one idle cycle after every pop.
    always_ff @(posedge clk) begin
        if (rst || flush || EN_LOOK_AHEAD != 0) begin
            gap_q <= FETCH_OK;
        end else begin
            case (gap_q)
                FETCH_OK: if (ack) gap_q <= GAP;
                GAP:      gap_q <= FETCH_OK;
                default:  gap_q <= FETCH_OK;
            endcase
        end
    end

    assign bus.fifo_rd_ack = ack;
    assign bus.out_valid   = valid_q;
    assign bus.out_data    = e0_q;
    assign bus.buf_level   = lvl_q;
    assign bus.word_count  = cnt_q;

endmodule

// File: tb/tb_ref_sc_fifo_rd_stream.sv
// Bench: two engines (look-ahead with 32-bit count, gap mode with 4-bit count) fed by
// queue-based FIFO models and checked against a word-order / occupancy reference.
module tb_ref_sc_fifo_rd_stream;

    localparam int DW = 72;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_drv   [2];
    logic          flush_drv [2];
    logic          ready_drv [2];
    logic          empty_drv [2];
    logic [DW-1:0] data_drv  [2];
    logic [4:0]    level_drv [2];

    ref_sc_fifo_rd_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .CNT_WIDTH(32)) ifa ();
    ref_sc_fifo_rd_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .CNT_WIDTH(4))  ifb ();

    assign ifa.fifo_rd_empty = empty_drv[0];
    assign ifa.fifo_rd_level = level_drv[0];
    assign ifa.fifo_rd_data  = data_drv[0];
    assign ifa.out_ready     = ready_drv[0];
    assign ifb.fifo_rd_empty = empty_drv[1];
    assign ifb.fifo_rd_level = level_drv[1];
    assign ifb.fifo_rd_data  = data_drv[1];
    assign ifb.out_ready     = ready_drv[1];

    ref_sc_fifo_rd_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .EN_LOOK_AHEAD(1), .CNT_WIDTH(32)) dut_la (
        .clk(clk), .rst(rst_drv[0]), .flush(flush_drv[0]), .bus(ifa)
    );
    ref_sc_fifo_rd_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .EN_LOOK_AHEAD(0), .CNT_WIDTH(4)) dut_gap (
        .clk(clk), .rst(rst_drv[1]), .flush(flush_drv[1]), .bus(ifb)
    );

    // Reference state: FIFO contents, words owed downstream in order, words held in the engine.
    logic [DW-1:0] fq  [2][$];
    logic [DW-1:0] exq [2][$];
    int            lvl_m [2];
    logic [31:0]   cnt_m [2];
    logic          gap_m [2];
    logic          prev_ack [2];
    logic          armed [2];

    logic          obs_valid [2];
    logic [DW-1:0] obs_data  [2];
    logic [1:0]    obs_lvl   [2];
    logic [31:0]   obs_cnt   [2];
    logic          obs_ack   [2];
    logic          hs_obs    [2];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] w);
        fq[i].push_back(w);
        exq[i].push_back(w);
    endtask

    task automatic reset_model(input int i);
        fq[i].delete();
        exq[i].delete();
        lvl_m[i]    = 0;
        cnt_m[i]    = 32'd0;
        gap_m[i]    = 1'b0;
        prev_ack[i] = 1'b0;
    endtask

    task automatic monitor(input int i);
        logic          exp_ack;
        logic          hs;
        logic [DW-1:0] w;
        hs_obs[i] = 1'b0;
        if (!armed[i]) begin
            if (rst_drv[i]) begin
                reset_model(i);
                armed[i] = 1'b1;
            end
            return;
        end
        chk($sformatf("buf_level[%0d]", i), 128'(obs_lvl[i]), 128'(lvl_m[i]));
        chk($sformatf("out_valid[%0d]", i), 128'(obs_valid[i]), 128'(lvl_m[i] != 0));
        chk($sformatf("word_count[%0d]", i), 128'(obs_cnt[i]), 128'(cnt_m[i]));
        if (lvl_m[i] != 0 && exq[i].size() > 0)
            chk($sformatf("out_data[%0d]", i), 128'(obs_data[i]), 128'(exq[i][0]));
        exp_ack = !empty_drv[i] && !gap_m[i] && (lvl_m[i] < 2) && !flush_drv[i];
        chk($sformatf("fifo_rd_ack[%0d]", i), 128'(obs_ack[i]), 128'(exp_ack));
        if (obs_ack[i]) begin
            chk($sformatf("ack_at_full[%0d]", i), 128'(lvl_m[i] == 2), 128'(0));
            if (i == 1) chk("adjacent_ack", 128'(prev_ack[i]), 128'(0));
        end
        hs = obs_valid[i] && ready_drv[i];
        if (rst_drv[i]) begin
            reset_model(i);
            return;
        end
        if (flush_drv[i]) begin
            fq[i].delete();
            exq[i].delete();
            lvl_m[i]    = 0;
            gap_m[i]    = 1'b0;
            prev_ack[i] = 1'b0;
            return;
        end
        if (hs) begin
            hs_obs[i] = 1'b1;
            if (exq[i].size() > 0) begin
                w = exq[i].pop_front();
                chk($sformatf("delivered[%0d]", i), 128'(obs_data[i]), 128'(w));
            end else begin
                chk($sformatf("spurious_valid[%0d]", i), 128'(obs_valid[i]), 128'(0));
            end
            cnt_m[i] = (cnt_m[i] + 32'd1) & ((i == 1) ? 32'hF : 32'hFFFF_FFFF);
            if (lvl_m[i] > 0) lvl_m[i]--;
        end
        if (obs_ack[i]) begin
            if (fq[i].size() > 0) void'(fq[i].pop_front());
            lvl_m[i]++;
        end
        gap_m[i]    = obs_ack[i] && (i == 1);
        prev_ack[i] = obs_ack[i];
    endtask

    // One clock: present FIFO outputs, check at the falling edge, return 2 time units after the rising edge.
    task automatic cycle();
        logic [95:0] g;
        for (int i = 0; i < 2; i++) begin
            g = {$urandom(), $urandom(), $urandom()};
            empty_drv[i] = rst_drv[i] || (fq[i].size() == 0);
            data_drv[i]  = (empty_drv[i] || gap_m[i]) ? g[DW-1:0] : fq[i][0];
            level_drv[i] = (fq[i].size() > 16) ? 5'd16 : 5'(fq[i].size());
        end
        @(negedge clk);
        obs_valid[0] = ifa.out_valid;  obs_valid[1] = ifb.out_valid;
        obs_data[0]  = ifa.out_data;   obs_data[1]  = ifb.out_data;
        obs_lvl[0]   = ifa.buf_level;  obs_lvl[1]   = ifb.buf_level;
        obs_cnt[0]   = ifa.word_count; obs_cnt[1]   = 32'(ifb.word_count);
        obs_ack[0]   = ifa.fifo_rd_ack; obs_ack[1]  = ifb.fifo_rd_ack;
        monitor(0);
        monitor(1);
        cyc++;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int first_ack, first_hs, last_hs, n_hs, n_ack, span, pushed, delivered;
        logic [31:0] cnt_before;
        logic [DW-1:0] got;
        logic [95:0] r;

        for (int i = 0; i < 2; i++) begin
            rst_drv[i] = 1'b1; flush_drv[i] = 1'b0; ready_drv[i] = 1'b0;
            empty_drv[i] = 1'b1; data_drv[i] = '0; level_drv[i] = 5'd0;
            armed[i] = 1'b0; gap_m[i] = 1'b0; hs_obs[i] = 1'b0;
            lvl_m[i] = 0; cnt_m[i] = 32'd0; prev_ack[i] = 1'b0;
        end
        repeat (2) cycle();
        rst_drv[0] = 1'b0; rst_drv[1] = 1'b0;
        cycle();
        chk("reset_valid", 128'(obs_valid[0]), 128'(0));
        chk("reset_level", 128'(obs_lvl[1]), 128'(0));
        chk("reset_count", 128'(obs_cnt[0]), 128'(0));
        chk("reset_data", 128'(obs_data[0]), 128'(0));
        chk("reset_ack", 128'(obs_ack[1]), 128'(0));

        // Basic drain, look-ahead, always ready.
        ready_drv[0] = 1'b1;
        for (int k = 1; k <= 8; k++) push(0, DW'(k));
        first_ack = -1; first_hs = -1; last_hs = -1; n_hs = 0;
        for (int t = 0; t < 40 && n_hs < 8; t++) begin
            cycle();
            if (obs_ack[0] && first_ack < 0) first_ack = cyc;
            if (hs_obs[0]) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                n_hs++;
            end
        end
        chk("drain_words", 128'(n_hs), 128'(8));
        chk("drain_first_latency", 128'(first_hs - first_ack), 128'(1));
        chk("drain_consecutive", 128'(last_hs - first_hs), 128'(7));
        cycle();
        chk("drain_count", 128'(obs_cnt[0]), 128'(8));
        chk("drain_level", 128'(obs_lvl[0]), 128'(0));

        // Gap mode drain.
        ready_drv[1] = 1'b1;
        for (int k = 1; k <= 8; k++) push(1, DW'(k));
        first_ack = -1; last_hs = -1; n_hs = 0;
        for (int t = 0; t < 60 && n_hs < 8; t++) begin
            cycle();
            if (obs_ack[1] && first_ack < 0) first_ack = cyc;
            if (hs_obs[1]) begin
                last_hs = cyc;
                n_hs++;
            end
        end
        span = last_hs - first_ack + 1;
        chk("gap_words", 128'(n_hs), 128'(8));
        chk("gap_span_15_to_17", 128'(span >= 15 && span <= 17), 128'(1));
        cycle();
        chk("gap_count", 128'(obs_cnt[1]), 128'(8));

        // Backpressure: stalled sink, then release.
        ready_drv[0] = 1'b0;
        for (int k = 0; k < 6; k++) push(0, DW'(8'hA0 + k));
        n_ack = 0;
        for (int t = 0; t < 10; t++) begin
            cycle();
            if (obs_ack[0]) n_ack++;
            if (obs_lvl[0] == 2'd2) chk("bp_stall_data", 128'(obs_data[0]), 128'(8'hA0));
        end
        chk("bp_acks", 128'(n_ack), 128'(2));
        chk("bp_level", 128'(obs_lvl[0]), 128'(2));
        chk("bp_head", 128'(obs_data[0]), 128'(8'hA0));
        ready_drv[0] = 1'b1;
        n_hs = 0;
        for (int t = 0; t < 40 && n_hs < 6; t++) begin
            cycle();
            if (hs_obs[0]) n_hs++;
        end
        chk("bp_delivered", 128'(n_hs), 128'(6));
        chk("bp_nothing_owed", 128'(exq[0].size()), 128'(0));

        // Random words and random backpressure.
        rst_drv[0] = 1'b1; cycle(); rst_drv[0] = 1'b0; cycle();
        pushed = 0; delivered = 0;
        for (int t = 0; t < 6000 && delivered < 200; t++) begin
            if (pushed < 200 && fq[0].size() < 16 && $urandom_range(0, 3) != 0) begin
                r = {$urandom(), $urandom(), $urandom()};
                push(0, r[DW-1:0]);
                pushed++;
            end
            ready_drv[0] = 1'($urandom_range(0, 1));
            cycle();
            if (hs_obs[0]) delivered++;
        end
        ready_drv[0] = 1'b0;
        chk("rand_delivered", 128'(delivered), 128'(200));
        cycle();
        chk("rand_count", 128'(obs_cnt[0]), 128'(200));
        chk("rand_nothing_owed", 128'(exq[0].size()), 128'(0));

        // Flush with a full skid buffer and words still in the FIFO.
        for (int k = 0; k < 5; k++) push(0, DW'(8'h11 + k));
        for (int t = 0; t < 10 && obs_lvl[0] != 2'd2; t++) cycle();
        chk("flush_setup_level", 128'(obs_lvl[0]), 128'(2));
        chk("flush_setup_fifo", 128'(fq[0].size()), 128'(3));
        cnt_before = obs_cnt[0];
        flush_drv[0] = 1'b1; ready_drv[0] = 1'b1;
        cycle();
        chk("flush_cycle_ack", 128'(obs_ack[0]), 128'(0));
        flush_drv[0] = 1'b0;
        cycle();
        chk("flush_valid", 128'(obs_valid[0]), 128'(0));
        chk("flush_level", 128'(obs_lvl[0]), 128'(0));
        chk("flush_count", 128'(obs_cnt[0]), 128'(cnt_before));
        push(0, DW'(8'h55));
        n_hs = 0; got = '0;
        for (int t = 0; t < 10; t++) begin
            cycle();
            if (hs_obs[0]) begin
                n_hs++;
                got = obs_data[0];
            end
        end
        chk("post_flush_words", 128'(n_hs), 128'(1));
        chk("post_flush_data", 128'(got), 128'(8'h55));

        // Counter wrap on the 4-bit engine, then reset with a full buffer.
        rst_drv[1] = 1'b1; cycle(); rst_drv[1] = 1'b0; cycle();
        ready_drv[1] = 1'b1;
        pushed = 0; delivered = 0;
        for (int t = 0; t < 200 && delivered < 17; t++) begin
            if (pushed < 17 && fq[1].size() < 16) begin
                push(1, DW'(8'hC0 + pushed));
                pushed++;
            end
            cycle();
            if (hs_obs[1]) delivered++;
        end
        chk("wrap_delivered", 128'(delivered), 128'(17));
        cycle();
        chk("wrap_count", 128'(obs_cnt[1]), 128'(1));
        ready_drv[1] = 1'b0;
        for (int k = 0; k < 3; k++) push(1, DW'(8'hE0 + k));
        for (int t = 0; t < 20 && obs_lvl[1] != 2'd2; t++) cycle();
        chk("rst_setup_level", 128'(obs_lvl[1]), 128'(2));
        rst_drv[1] = 1'b1;
        cycle();
        rst_drv[1] = 1'b0;
        cycle();
        chk("rst_valid", 128'(obs_valid[1]), 128'(0));
        chk("rst_level", 128'(obs_lvl[1]), 128'(0));
        chk("rst_count", 128'(obs_cnt[1]), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
